sram_access_arbiter: RTL and testbench



---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_line_packer.sv | 77 +++++++
 rtl/sram_access_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_access_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM fill/read access path.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W    = 19;
   localparam int unsigned SRAM_WORD_W    = 32;
   localparam int unsigned WORDS_PER_LINE = 3;
   localparam int unsigned SRAM_LINE_W    = SRAM_WORD_W * WORDS_PER_LINE;

   // Which requester owns the SRAM port in the current cycle.
   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_WRITE = 2'd1,
      GNT_READ  = 2'd2
   } grant_t;

endpackage

// File: rtl/sram_line_packer.sv
// Packs incoming words into full SRAM lines and holds one completed line
// until the arbiter issues it. The first word of a line ends up in the MSBs.
module sram_line_packer #(
   parameter int unsigned WORD_W         = sram_pkg::SRAM_WORD_W,
   parameter int unsigned WORDS_PER_LINE = sram_pkg::WORDS_PER_LINE
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             restart,
   input  logic                             word_valid,
   input  logic [WORD_W-1:0]                word,
   output logic                             word_ready,
   input  logic                             line_issue,
   output logic [WORD_W*WORDS_PER_LINE-1:0] line,
   output logic                             line_pending
);

   localparam int unsigned LINE_W   = WORD_W * WORDS_PER_LINE;
   localparam int unsigned CNT_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] pack_q, pack_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              pending_q, pending_d;
   logic              last_word;
   logic              accept;

   // Handshake and next-state: a completed line may overwrite the line
   // register in the same cycle the previous line is being issued.
   always_comb begin
      last_word  = (cnt_q == LAST_CNT);
      word_ready = restart || !(last_word && pending_q && !line_issue);
      accept     = word_valid && word_ready && !restart;
      cnt_d      = cnt_q;
      pack_d     = pack_q;
      line_d     = line_q;
      pending_d  = pending_q;
      if (restart) begin
         cnt_d     = '0;
         pending_d = 1'b0;
      end else begin
         if (line_issue) begin
            pending_d = 1'b0;
         end
         if (accept) begin
            pack_d = {pack_q[LINE_W-WORD_W-1:0], word};
            if (last_word) begin
               cnt_d     = '0;
               line_d    = {pack_q[LINE_W-WORD_W-1:0], word};
               pending_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Packer state registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q     <= '0;
         pack_q    <= '0;
         line_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pack_q    <= pack_d;
         line_q    <= line_d;
         pending_q <= pending_d;
      end
   end

   assign line         = line_q;
   assign line_pending = pending_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one single-port SRAM between the packed write stream and a random
// read requester with round-robin arbitration; reads return after a fixed
// SRAM latency plus one capture stage.
module sram_access_arbiter #(
   parameter int unsigned ADDR_W         = sram_pkg::SRAM_ADDR_W,
   parameter int unsigned WORD_W         = sram_pkg::SRAM_WORD_W,
   parameter int unsigned WORDS_PER_LINE = sram_pkg::WORDS_PER_LINE,
   parameter int unsigned RD_LATENCY     = 2
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             wr_restart,
   input  logic                             wr_word_valid,
   input  logic [WORD_W-1:0]                wr_word,
   output logic                             wr_word_ready,
   output logic                             wr_wrap,
   input  logic                             rd_req_valid,
   input  logic [ADDR_W-1:0]                rd_req_addr,
   output logic                             rd_req_ready,
   output logic                             rd_rvalid,
   output logic [WORD_W*WORDS_PER_LINE-1:0] rd_rdata,
   output logic                             SRAM_CE,
   output logic                             SRAM_WE,
   output logic [ADDR_W-1:0]                SRAM_ADDR,
   output logic [WORD_W*WORDS_PER_LINE-1:0] SRAM_DATA_IN,
   input  logic [WORD_W*WORDS_PER_LINE-1:0] SRAM_DATA_OUT
);

   import sram_pkg::*;

   localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

   logic [LINE_W-1:0]     line;
   logic                  line_pending;
   logic                  wr_cand;
   logic                  wr_grant;
   grant_t                grant;
   grant_t                last_grant_q;
   logic [ADDR_W-1:0]     wr_addr_q;
   logic [RD_LATENCY-1:0] rd_pipe_q;

   sram_line_packer #(
      .WORD_W         (WORD_W),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_packer (
      .CLK          (CLK),
      .RST          (RST),
      .restart      (wr_restart),
      .word_valid   (wr_word_valid),
      .word         (wr_word),
      .word_ready   (wr_word_ready),
      .line_issue   (wr_grant),
      .line         (line),
      .line_pending (line_pending)
   );

   // Round-robin grant; a restart cycle withdraws the pending line.
   always_comb begin
      grant   = GNT_NONE;
      wr_cand = line_pending && !wr_restart;
      if (wr_cand && rd_req_valid) begin
         grant = (last_grant_q == GNT_WRITE) ? GNT_READ : GNT_WRITE;
      end else if (wr_cand) begin
         grant = GNT_WRITE;
      end else if (rd_req_valid) begin
         grant = GNT_READ;
      end
   end

   assign wr_grant     = (grant == GNT_WRITE);
   assign rd_req_ready = (grant == GNT_READ);

   // Remember the last winner so ties alternate; starts as READ so the
   // first tie favours the write side.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant_q <= GNT_READ;
      end else if (grant != GNT_NONE) begin
         last_grant_q <= grant;
      end
   end

   // Registered SRAM command and the self-incrementing write line address.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         SRAM_CE      <= 1'b0;
         SRAM_WE      <= 1'b0;
         SRAM_ADDR    <= '0;
         SRAM_DATA_IN <= '0;
         wr_addr_q    <= '0;
         wr_wrap      <= 1'b0;
      end else begin
         SRAM_CE <= 1'b0;
         SRAM_WE <= 1'b0;
         wr_wrap <= 1'b0;
         unique case (grant)
            GNT_WRITE: begin
               SRAM_CE      <= 1'b1;
               SRAM_WE      <= 1'b1;
               SRAM_ADDR    <= wr_addr_q;
               SRAM_DATA_IN <= line;
               wr_addr_q    <= wr_addr_q + ADDR_W'(1);
               wr_wrap      <= &wr_addr_q;
            end
            GNT_READ: begin
               SRAM_CE   <= 1'b1;
               SRAM_ADDR <= rd_req_addr;
            end
            default: ;
         endcase
         // No write is granted in a restart cycle, so this cannot race an issue.
         if (wr_restart) begin
            wr_addr_q <= '0;
         end
      end
   end

   // Track each read command on the port through the SRAM latency.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_pipe_q <= '0;
      end else begin
         rd_pipe_q[0] <= SRAM_CE && !SRAM_WE;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
         end
      end
   end

   // Capture read data as its valid bit leaves the latency pipe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_rvalid <= 1'b0;
         rd_rdata  <= '0;
      end else begin
         rd_rvalid <= rd_pipe_q[RD_LATENCY-1];
         if (rd_pipe_q[RD_LATENCY-1]) begin
            rd_rdata <= SRAM_DATA_OUT;
         end
      end
   end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a packer model pushes expected
// writes, read handshakes push expected returns with their due cycle.
module tb_sram_access_arbiter;

   localparam int unsigned LAT = 2;

   typedef struct {
      logic [18:0] addr;
      logic [95:0] data;
   } wr_exp_t;

   typedef struct {
      logic [95:0] data;
      int          due;
   } rd_exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        wr_restart = 1'b0;
   logic        wr_word_valid = 1'b0;
   logic [31:0] wr_word = '0;
   logic        wr_word_ready;
   logic        wr_wrap;
   logic        rd_req_valid = 1'b0;
   logic [18:0] rd_req_addr = '0;
   logic        rd_req_ready;
   logic        rd_rvalid;
   logic [95:0] rd_rdata;
   logic        SRAM_CE;
   logic        SRAM_WE;
   logic [18:0] SRAM_ADDR;
   logic [95:0] SRAM_DATA_IN;
   logic [95:0] SRAM_DATA_OUT;

   // Small-address instance used only to reach the wrap boundary quickly.
   logic        s_valid = 1'b0;
   logic [31:0] s_word = '0;
   logic        s_ready, s_wrap, s_rready, s_rvalid, s_ce, s_we;
   logic [2:0]  s_addr;
   logic [95:0] s_rdata, s_din;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_writes = 0;
   int n_rvalid = 0;
   int n_accepts = 0;
   int s_k = 0;
   logic [18:0] last_wr_addr;
   logic [95:0] last_wr_data;

   wr_exp_t wq[$];
   rd_exp_t rq[$];
   logic    cmd_log[$];
   int          m_cnt = 0;
   logic [18:0] m_addr = '0;
   logic [95:0] m_pack = '0;

   logic        sm_vld  [LAT];
   logic [95:0] sm_data [LAT];

   sram_access_arbiter #(.RD_LATENCY(LAT)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .wr_restart    (wr_restart),
      .wr_word_valid (wr_word_valid),
      .wr_word       (wr_word),
      .wr_word_ready (wr_word_ready),
      .wr_wrap       (wr_wrap),
      .rd_req_valid  (rd_req_valid),
      .rd_req_addr   (rd_req_addr),
      .rd_req_ready  (rd_req_ready),
      .rd_rvalid     (rd_rvalid),
      .rd_rdata      (rd_rdata),
      .SRAM_CE       (SRAM_CE),
      .SRAM_WE       (SRAM_WE),
      .SRAM_ADDR     (SRAM_ADDR),
      .SRAM_DATA_IN  (SRAM_DATA_IN),
      .SRAM_DATA_OUT (SRAM_DATA_OUT)
   );

   sram_access_arbiter #(.ADDR_W(3), .RD_LATENCY(LAT)) dut_small (
      .CLK           (CLK),
      .RST           (RST),
      .wr_restart    (1'b0),
      .wr_word_valid (s_valid),
      .wr_word       (s_word),
      .wr_word_ready (s_ready),
      .wr_wrap       (s_wrap),
      .rd_req_valid  (1'b0),
      .rd_req_addr   (3'd0),
      .rd_req_ready  (s_rready),
      .rd_rvalid     (s_rvalid),
      .rd_rdata      (s_rdata),
      .SRAM_CE       (s_ce),
      .SRAM_WE       (s_we),
      .SRAM_ADDR     (s_addr),
      .SRAM_DATA_IN  (s_din),
      .SRAM_DATA_OUT (96'd0)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [95:0] sram_data(input logic [18:0] a);
      logic [31:0] x;
      x = {13'h0, a};
      return {x ^ 32'hA5A5_A5A5, x + 32'h1234_5678, ~x};
   endfunction

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // SRAM model: data for a read command appears LAT cycles later.
   initial for (int i = 0; i < LAT; i++) sm_vld[i] = 1'b0;
   always @(posedge CLK) begin
      sm_vld[0]  <= SRAM_CE && !SRAM_WE;
      sm_data[0] <= sram_data(SRAM_ADDR);
      for (int i = 1; i < LAT; i++) begin
         sm_vld[i]  <= sm_vld[i-1];
         sm_data[i] <= sm_data[i-1];
      end
   end
   always_comb SRAM_DATA_OUT = sm_vld[LAT-1] ? sm_data[LAT-1] : 96'hBADBADBAD_BADBADBAD_BADBAD;

   // Monitor/scoreboard on the falling edge, away from the active edge.
   always @(negedge CLK) begin
      if (!RST) begin
         if (wr_restart) begin
            m_cnt  = 0;
            m_addr = '0;
         end else if (wr_word_valid && wr_word_ready) begin
            n_accepts++;
            m_pack = {m_pack[63:0], wr_word};
            if (m_cnt == 2) begin
               wq.push_back('{m_addr, m_pack});
               m_addr = m_addr + 19'd1;
               m_cnt  = 0;
            end else begin
               m_cnt++;
            end
         end
         if (rd_req_valid && rd_req_ready)
            rq.push_back('{sram_data(rd_req_addr), cyc + LAT + 2});
         if (SRAM_CE) begin
            cmd_log.push_back(SRAM_WE);
            if (SRAM_WE) begin
               wr_exp_t e;
               n_writes++;
               last_wr_addr = SRAM_ADDR;
               last_wr_data = SRAM_DATA_IN;
               check_eq("wr_wrap", 128'(wr_wrap), 128'(0));
               if (wq.size() == 0) begin
                  check_eq("unexpected write", 128'(1), 128'(0));
               end else begin
                  e = wq.pop_front();
                  check_eq("write addr", 128'(SRAM_ADDR), 128'(e.addr));
                  check_eq("write data", 128'(SRAM_DATA_IN), 128'(e.data));
               end
            end
         end
         if (rd_rvalid) begin
            rd_exp_t r;
            n_rvalid++;
            if (rq.size() == 0) begin
               check_eq("unexpected rd_rvalid", 128'(1), 128'(0));
            end else begin
               r = rq.pop_front();
               check_eq("rd_rdata", 128'(rd_rdata), 128'(r.data));
               check_eq("rd latency", 128'(cyc), 128'(r.due));
            end
         end
         if (s_ce) begin
            check_eq("small we", 128'(s_we), 128'(1));
            check_eq("small addr", 128'(s_addr), 128'(s_k % 8));
            check_eq("small data", 128'(s_din),
                     128'({32'(3 * s_k), 32'(3 * s_k + 1), 32'(3 * s_k + 2)}));
            check_eq("small wrap", 128'(s_wrap), 128'((s_k % 8) == 7));
            s_k++;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      wr_restart = 1'b0;
      wr_word_valid = 1'b0;
      rd_req_valid = 1'b0;
      s_valid = 1'b0;
      wq.delete();
      rq.delete();
      m_cnt = 0;
      m_addr = '0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, output int stalls);
      int guard;
      stalls = 0;
      guard = 0;
      wr_word_valid = 1'b1;
      wr_word = w;
      @(negedge CLK);
      while (!wr_word_ready && guard < 50) begin
         stalls++;
         guard++;
         @(negedge CLK);
      end
      if (!wr_word_ready) check_eq("wr_word_ready timeout", 128'(0), 128'(1));
      @(posedge CLK);
      #1 wr_word_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st, stall_total, wr0, rv0, hs, guard, acc0;
      logic exp_seq [10];
      exp_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset values
      #1 RST = 1'b1;
      #2;
      check_eq("rst SRAM_CE", 128'(SRAM_CE), 128'(0));
      check_eq("rst SRAM_WE", 128'(SRAM_WE), 128'(0));
      check_eq("rst SRAM_ADDR", 128'(SRAM_ADDR), 128'(0));
      check_eq("rst SRAM_DATA_IN", 128'(SRAM_DATA_IN), 128'(0));
      check_eq("rst rd_rvalid", 128'(rd_rvalid), 128'(0));
      check_eq("rst rd_rdata", 128'(rd_rdata), 128'(0));
      check_eq("rst wr_wrap", 128'(wr_wrap), 128'(0));
      check_eq("rst wr_word_ready", 128'(wr_word_ready), 128'(1));
      rd_req_valid = 1'b1;
      #1 check_eq("rst rd_req_ready valid", 128'(rd_req_ready), 128'(1));
      rd_req_valid = 1'b0;
      #1 check_eq("rst rd_req_ready idle", 128'(rd_req_ready), 128'(0));
      apply_reset();

      // Basic line packing
      send_word(32'h1111_1111, st);
      send_word(32'h2222_2222, st);
      send_word(32'h3333_3333, st);
      wait_cycles(4);
      check_eq("t1 writes", 128'(n_writes), 128'(1));
      check_eq("t1 addr", 128'(last_wr_addr), 128'(0));
      check_eq("t1 data", 128'(last_wr_data), 128'(96'h11111111_22222222_33333333));
      send_word(32'h4444_4444, st);
      send_word(32'h5555_5555, st);
      send_word(32'h6666_6666, st);
      wait_cycles(4);
      check_eq("t1 second addr", 128'(last_wr_addr), 128'(1));

      // 300-word stream after restart
      wr_restart = 1'b1;
      tick();
      wr_restart = 1'b0;
      wr0 = n_writes;
      stall_total = 0;
      for (int i = 0; i < 300; i++) begin
         send_word(32'h5000_0000 + 32'(i), st);
         stall_total += st;
      end
      wait_cycles(4);
      check_eq("stream stalls", 128'(stall_total), 128'(0));
      check_eq("stream writes", 128'(n_writes - wr0), 128'(100));
      check_eq("stream last addr", 128'(last_wr_addr), 128'(99));

      // Contention: first tie goes to WRITE, then alternation at each tie
      apply_reset();
      cmd_log.delete();
      rv0 = n_rvalid;
      acc0 = n_accepts;
      fork
         begin
            for (int i = 0; i < 12; i++) send_word(32'hC000_0000 + 32'(i), st);
         end
         begin
            guard = 0;
            do begin
               @(posedge CLK);
               guard++;
            end while (n_accepts < acc0 + 3 && guard < 50);
            #1;
            rd_req_valid = 1'b1;
            rd_req_addr = 19'h00ABC;
            hs = 0;
            guard = 0;
            while (hs < 6 && guard < 100) begin
               @(negedge CLK);
               if (rd_req_valid && rd_req_ready) hs++;
               guard++;
            end
            @(posedge CLK);
            #1 rd_req_valid = 1'b0;
            check_eq("contention reads", 128'(hs), 128'(6));
         end
      join
      wait_cycles(10);
      check_eq("contention cmds", 128'(cmd_log.size()), 128'(10));
      for (int i = 0; i < 10; i++)
         if (i < cmd_log.size()) check_eq("grant order", 128'(cmd_log[i]), 128'(exp_seq[i]));
      check_eq("contention rvalids", 128'(n_rvalid - rv0), 128'(6));

      // Restart discards a partial line and a concurrent word
      send_word(32'hDEAD_0001, st);
      send_word(32'hDEAD_0002, st);
      wr_restart = 1'b1;
      wr_word_valid = 1'b1;
      wr_word = 32'hBAD0_BAD0;
      @(negedge CLK);
      check_eq("ready during restart", 128'(wr_word_ready), 128'(1));
      @(posedge CLK);
      #1;
      wr_restart = 1'b0;
      wr_word_valid = 1'b0;
      wr0 = n_writes;
      send_word(32'h0000_000A, st);
      send_word(32'h0000_000B, st);
      send_word(32'h0000_000C, st);
      wait_cycles(5);
      check_eq("restart writes", 128'(n_writes - wr0), 128'(1));
      check_eq("restart addr", 128'(last_wr_addr), 128'(0));
      check_eq("restart data", 128'(last_wr_data), 128'(96'h0000000A_0000000B_0000000C));

      // Address wrap on the small instance: 10 lines over an 8-line space
      for (int i = 0; i < 30; i++) begin
         guard = 0;
         s_valid = 1'b1;
         s_word = 32'(i);
         @(negedge CLK);
         while (!s_ready && guard < 50) begin
            guard++;
            @(negedge CLK);
         end
         @(posedge CLK);
         #1 s_valid = 1'b0;
      end
      wait_cycles(5);
      check_eq("small line count", 128'(s_k), 128'(10));

      // Reset in the middle of back-to-back reads
      rd_req_valid = 1'b1;
      rd_req_addr = 19'd1;
      hs = 0;
      guard = 0;
      while (hs < 3 && guard < 50) begin
         @(negedge CLK);
         if (rd_req_valid && rd_req_ready) hs++;
         guard++;
         @(posedge CLK);
         #1;
         rd_req_addr = 19'(hs + 1);
         if (hs == 3) rd_req_valid = 1'b0;
      end
      check_eq("midrst reads issued", 128'(hs), 128'(3));
      @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      check_eq("midrst SRAM_CE", 128'(SRAM_CE), 128'(0));
      check_eq("midrst SRAM_ADDR", 128'(SRAM_ADDR), 128'(0));
      check_eq("midrst SRAM_DATA_IN", 128'(SRAM_DATA_IN), 128'(0));
      check_eq("midrst rd_rvalid", 128'(rd_rvalid), 128'(0));
      check_eq("midrst rd_rdata", 128'(rd_rdata), 128'(0));
      rv0 = n_rvalid;
      apply_reset();
      wait_cycles(10);
      check_eq("no rvalid after reset", 128'(n_rvalid - rv0), 128'(0));
      wr0 = n_writes;
      send_word(32'h7777_0001, st);
      send_word(32'h7777_0002, st);
      send_word(32'h7777_0003, st);
      wait_cycles(4);
      check_eq("post-reset writes", 128'(n_writes - wr0), 128'(1));
      check_eq("post-reset addr", 128'(last_wr_addr), 128'(0));

      check_eq("write queue drained", 128'(wq.size()), 128'(0));
      check_eq("read queue drained", 128'(rq.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
